fetch_mem_responder: RTL

FETCH_MEM_RESPONDER -- requirements
Module: fetch_mem_responder

---
 rtl/fetch_resp_pkg.sv | 26 ++
 rtl/fetch_mem_responder_if.sv | 24 ++
 rtl/fetch_mem_responder_hitbuf.sv | 40 ++++
 rtl/fetch_mem_responder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fetch_resp_pkg.sv
// Shared types and constants for the fetch memory responder.
package fetch_resp_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned LATENCY_MIN = 2;
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Request fields captured when an access is accepted.
    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/fetch_mem_responder_if.sv
// Requester-facing bus of the fetch memory responder.
interface fetch_mem_responder_if;

    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, Done, Stall, CacheHit, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, Done, Stall, CacheHit, err
    );

endinterface

// File: rtl/fetch_mem_responder_hitbuf.sv
// Single-entry read hit buffer: tag/data/valid with same-cycle lookup.
module resp_hitbuf
    import fetch_resp_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_idx,
    output logic              hit_c,
    output logic [DATA_W-1:0] data_c,
    input  logic              fill,
    input  logic              write,
    input  logic [ADDR_W-1:0] upd_idx,
    input  logic [DATA_W-1:0] upd_data
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;

    // Read misses refill the entry; writes to the buffered word keep it coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill) begin
            valid_q <= 1'b1;
            tag_q   <= upd_idx;
            data_q  <= upd_data;
        end else if (write && valid_q && (tag_q == upd_idx)) begin
            data_q  <= upd_data;
        end
    end

    assign hit_c  = valid_q && (tag_q == lookup_idx);
    assign data_c = data_q;

endmodule

// File: rtl/fetch_mem_responder.sv
// Fixed-latency word memory responder with an optional one-entry read hit
// buffer, enabled by defining FETCH_RESP_HITBUF_EN.
module fetch_mem_responder
    import fetch_resp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_mem_responder_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("fetch_mem_responder: LATENCY out of range");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] bus_idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              hit_c;
    logic [DATA_W-1:0] hit_data_c;
    logic              fill;
    logic              wr_commit;
    logic              done;
    logic              stall;
    logic              cache_hit;
    logic              err;
    logic [DATA_W-1:0] data_out;
    logic              unused_addr;

    // Upper address bits alias onto the same word.
    assign bus_idx     = bus.Addr[ADDR_W:1];
    assign unused_addr = ^bus.Addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        idx_d     = idx_q;
        done      = 1'b0;
        stall     = 1'b0;
        cache_hit = 1'b0;
        err       = 1'b0;
        data_out  = '0;
        fill      = 1'b0;
        wr_commit = 1'b0;
        // Outputs stay quiet while reset is held, whatever the requester drives.
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.Rd || bus.Wr) begin
                        if ((bus.Rd && bus.Wr) || bus.Addr[0]) begin
                            err = 1'b1;
                        end else if (bus.Rd && hit_c) begin
                            done      = 1'b1;
                            cache_hit = 1'b1;
                            data_out  = hit_data_c;
                        end else begin
                            stall      = 1'b1;
                            req_d.op   = bus.Wr ? OP_WR : OP_RD;
                            req_d.data = bus.DataIn;
                            idx_d      = bus_idx;
                            cnt_d      = CNT_W'(LATENCY - 1);
                            state_d    = BUSY;
                        end
                    end
                end
                BUSY: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                    if (req_q.op == OP_RD) begin
                        data_out = rd_q;
                        fill     = 1'b1;
                    end else begin
                        wr_commit = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Storage is never reset; the read port tracks the latched index so the
    // word is ready by the time the access reaches DONE.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[idx_q] <= req_q.data;
        end
        rd_q <= mem[idx_q];
    end

`ifdef FETCH_RESP_HITBUF_EN
    resp_hitbuf #(
        .ADDR_W (ADDR_W)
    ) u_hitbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_idx (bus_idx),
        .hit_c      (hit_c),
        .data_c     (hit_data_c),
        .fill       (fill),
        .write      (wr_commit),
        .upd_idx    (idx_q),
        .upd_data   (fill ? rd_q : req_q.data)
    );
`else
    logic unused_fill;
    assign unused_fill = fill;
    assign hit_c       = 1'b0;
    assign hit_data_c  = '0;
`endif

    assign bus.Done     = done;
    assign bus.Stall    = stall;
    assign bus.CacheHit = cache_hit;
    assign bus.err      = err;
    assign bus.DataOut  = data_out;

endmodule
